// File: rtl/scan_sequencer.sv
// Channel scanner: walks the enabled bits of a 16-bit mask up or down, holding each
// index for dwell+1 cycles, and drives the 4-to-16 decoder select with registered outputs.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        mask,
  output logic [3:0]         idx,
  output logic               idx_valid,
  output logic               step,
  output logic               wrap,
  output logic               done,
  output logic               busy
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         idx_reg, idx_next;
  logic               idx_valid_reg, idx_valid_next;
  logic               step_reg, step_next;
  logic               wrap_reg, wrap_next;
  logic               done_reg, done_next;
  logic               busy_reg, busy_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic               mode_reg, mode_next;
  logic               dir_reg, dir_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic [15:0]        mask_reg, mask_next;

  logic [15:0] asc_rot, desc_rot;
  logic [3:0]  asc_k, desc_k, next_idx, first_lo, first_hi;
  logic        wrapped, at_end, start_ok;

  // Bit k of each rotated view is the channel k+1 steps away from idx_reg,
  // so the lowest set bit gives the distance to the next enabled channel.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rot
      localparam logic [3:0] OFF = 4'(gi + 1);
      assign asc_rot[gi]  = mask_reg[idx_reg + OFF];
      assign desc_rot[gi] = mask_reg[idx_reg - OFF];
    end
  endgenerate

  always_comb begin
    asc_k    = 4'd0;
    desc_k   = 4'd0;
    first_lo = 4'd0;
    first_hi = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (asc_rot[i])  asc_k    = 4'(i);
      if (desc_rot[i]) desc_k   = 4'(i);
      if (mask[i])     first_lo = 4'(i);
    end
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) first_hi = 4'(i);
    end
  end

  assign next_idx = dir_reg ? (idx_reg - desc_k - 4'd1) : (idx_reg + asc_k + 4'd1);
  assign wrapped  = dir_reg ? (next_idx >= idx_reg) : (next_idx <= idx_reg);
  assign at_end   = (cnt_reg == dwell_reg);
  assign start_ok = start && !stop && (mask != 16'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= 4'd0;
      idx_valid_reg <= 1'b0;
      step_reg      <= 1'b0;
      wrap_reg      <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      cnt_reg       <= '0;
      mode_reg      <= 1'b0;
      dir_reg       <= 1'b0;
      dwell_reg     <= '0;
      mask_reg      <= 16'd0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      idx_valid_reg <= idx_valid_next;
      step_reg      <= step_next;
      wrap_reg      <= wrap_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      cnt_reg       <= cnt_next;
      mode_reg      <= mode_next;
      dir_reg       <= dir_next;
      dwell_reg     <= dwell_next;
      mask_reg      <= mask_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_ok) state_next = SCAN;
      SCAN: if (stop || (at_end && mode_reg && wrapped)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    mode_next      = mode_reg;
    dir_next       = dir_reg;
    dwell_next     = dwell_reg;
    mask_next      = mask_reg;
    step_next      = 1'b0;
    wrap_next      = 1'b0;
    done_next      = 1'b0;
    idx_valid_next = (state_next == SCAN);
    busy_next      = (state_next == SCAN);
    if (state_reg == IDLE) begin
      if (start_ok) begin
        mode_next  = mode;
        dir_next   = dir;
        dwell_next = dwell;
        mask_next  = mask;
        idx_next   = dir ? first_hi : first_lo;
        cnt_next   = '0;
        step_next  = 1'b1;
      end
    end else if (!stop) begin
      if (!at_end) begin
        cnt_next = cnt_reg + 1'b1;
      end else if (mode_reg && wrapped) begin
        done_next = 1'b1;
      end else begin
        idx_next  = next_idx;
        cnt_next  = '0;
        step_next = 1'b1;
        wrap_next = wrapped;
      end
    end
  end

  assign idx       = idx_reg;
  assign idx_valid = idx_valid_reg;
  assign step      = step_reg;
  assign wrap      = wrap_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: expected output vectors are queued as each
// stimulus step is driven and checked against the DUT just after the next edge.
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, mode, dir;
  logic [7:0]  dwell;
  logic [15:0] mask;
  logic [3:0]  idx;
  logic        idx_valid, step, wrap, done, busy;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .dwell(dwell), .mask(mask), .idx(idx), .idx_valid(idx_valid), .step(step),
    .wrap(wrap), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Queue the expected {idx,idx_valid,step,wrap,done,busy} after the coming edge, then check it.
  task automatic cyc(input string tag, input logic [3:0] e_idx, input logic e_v,
                     input logic e_s, input logic e_w, input logic e_d, input logic e_b);
    logic [8:0] obs, expv;
    exp_q.push_back({e_idx, e_v, e_s, e_w, e_d, e_b});
    @(posedge clk);
    #1;
    obs  = {idx, idx_valid, step, wrap, done, busy};
    expv = exp_q.pop_front();
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: idx/valid/step/wrap/done/busy observed=%h/%b%b%b%b%b expected=%h/%b%b%b%b%b",
             tag, obs[8:5], obs[4], obs[3], obs[2], obs[1], obs[0],
             expv[8:5], expv[4], expv[3], expv[2], expv[1], expv[0]);
    end
  endtask

  initial begin
    logic [3:0] chans[4];
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; mode = 1'b0; dir = 1'b0;
    dwell = 8'd0; mask = 16'hFFFF;

    // Reset held with start high
    cyc("reset", 4'd0, 0, 0, 0, 0, 0);
    cyc("reset", 4'd0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Continuous ascending, dwell 0
    cyc("asc_first", 4'd0, 1, 1, 0, 0, 1);
    start = 1'b0;
    for (int i = 1; i < 16; i++) cyc("asc", 4'(i), 1, 1, 0, 0, 1);
    cyc("asc_wrap", 4'd0, 1, 1, 1, 0, 1);
    cyc("asc_after_wrap", 4'd1, 1, 1, 0, 0, 1);
    stop = 1'b1;
    cyc("asc_stop", 4'd1, 0, 0, 0, 0, 0);
    stop = 1'b0;

    // Single sweep; config and start changes during the scan must be ignored
    mask = 16'h8421; dwell = 8'd2; mode = 1'b1; dir = 1'b0; start = 1'b1;
    chans[0] = 4'd0; chans[1] = 4'd5; chans[2] = 4'd10; chans[3] = 4'd15;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 3; r++) begin
        cyc("sweep", chans[c], 1, (r == 0), 0, 0, 1);
        mask = 16'h0000; dir = 1'b1; dwell = 8'd0; mode = 1'b0;
      end
    end
    cyc("sweep_done", 4'd15, 0, 0, 0, 1, 0);
    cyc("sweep_idle", 4'd15, 0, 0, 0, 0, 0);
    start = 1'b0;

    // Descending continuous, dwell 1
    mask = 16'h00F0; dir = 1'b1; dwell = 8'd1; mode = 1'b0; start = 1'b1;
    cyc("desc", 4'd7, 1, 1, 0, 0, 1);
    start = 1'b0;
    cyc("desc", 4'd7, 1, 0, 0, 0, 1);
    cyc("desc", 4'd6, 1, 1, 0, 0, 1);
    cyc("desc", 4'd6, 1, 0, 0, 0, 1);
    cyc("desc", 4'd5, 1, 1, 0, 0, 1);
    cyc("desc", 4'd5, 1, 0, 0, 0, 1);
    cyc("desc", 4'd4, 1, 1, 0, 0, 1);
    cyc("desc", 4'd4, 1, 0, 0, 0, 1);
    cyc("desc_wrap", 4'd7, 1, 1, 1, 0, 1);
    cyc("desc", 4'd7, 1, 0, 0, 0, 1);
    stop = 1'b1;
    cyc("desc_stop", 4'd7, 0, 0, 0, 0, 0);
    stop = 1'b0;

    // Stop on the advance cycle of idx 3, then ignored starts
    mask = 16'hFFFF; dir = 1'b0; dwell = 8'd3; mode = 1'b0; start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        cyc("stop_scan", 4'(c), 1, (r == 0), 0, 0, 1);
        start = 1'b0;
      end
    end
    stop = 1'b1;
    cyc("stop_adv", 4'd3, 0, 0, 0, 0, 0);
    start = 1'b1;
    cyc("start_and_stop", 4'd3, 0, 0, 0, 0, 0);
    stop = 1'b0; mask = 16'h0000;
    cyc("start_no_mask", 4'd3, 0, 0, 0, 0, 0);
    mask = 16'h0040; dwell = 8'd1;
    cyc("one_ch", 4'd6, 1, 1, 0, 0, 1);
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      cyc("one_ch", 4'd6, 1, 0, 0, 0, 1);
      cyc("one_ch_wrap", 4'd6, 1, 1, 1, 0, 1);
    end

    // Reset mid-scan
    rst_n = 1'b0;
    cyc("rst_mid", 4'd0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc("rst_after", 4'd0, 0, 0, 0, 0, 0);

    // Maximum dwell: single channel held 256 cycles, then done
    mask = 16'h0002; dwell = 8'd255; mode = 1'b1; dir = 1'b0; start = 1'b1;
    for (int r = 0; r < 256; r++) begin
      cyc("max_dwell", 4'd1, 1, (r == 0), 0, 0, 1);
      start = 1'b0;
    end
    cyc("max_dwell_done", 4'd1, 0, 0, 0, 1, 0);
    cyc("max_dwell_idle", 4'd1, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
